// File: rtl/uart_mon_pkg.sv
// Shared constants and types for the UART hex history monitor.
// No logic and no latency; no backpressure.
// Holds the segment table, the mode encoding and the history entry layout.
package uart_mon_pkg;

    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_DP   = 8'h80;

    // Index 0 is the rightmost element: SEG7_HEX[n] is the glyph for nibble n.
    localparam logic [15:0][7:0] SEG7_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h27, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef enum logic [1:0] {
        MODE_FIRST  = 2'd0,
        MODE_LIVE   = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/uart_hex_monitor_seg7.sv
// Nibble plus decimal point to one active-low 7-segment digit.
// Purely combinational, zero latency.
// No flow control; the output simply follows the inputs.
module seg7_hex_enc
    import uart_mon_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    always_comb begin
        seg_n = ~(SEG7_HEX[nibble] | (dp ? SEG_DP : 8'h00));
    end

endmodule

// File: rtl/uart_hex_monitor.sv
// Byte history of the UART receiver stream shown on NDIG active-low hex digits.
// History and counters update on the strobe edge; hex_o follows one edge later.
// Never stalls: a full history overwrites its oldest entry, rejected bytes are counted.
module uart_hex_monitor
    import uart_mon_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int NDIG        = 4,
    parameter  int TICK_CYCLES = 120000000,
    parameter  int CNT_W       = 16,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_perr_i,
    input  logic                rx_ferr_i,
    input  logic [1:0]          mode_i,
    input  logic                clear_i,
    output logic [8*NDIG-1:0]   hex_o,
    output logic [CNT_W-1:0]    rx_count_o,
    output logic [CNT_W-1:0]    drop_count_o,
    output logic [AW-1:0]       view_idx_o
);

    localparam int           TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

    mode_e             mode;
    mode_e             mode_q;
    logic              mode_chg;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     view_idx;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fill;
    logic [AW:0]       view_inc;
    logic              captured;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  drop_count;
    logic              accept;
    logic              drop;
    entry_t            mem [DEPTH];
    entry_t            cur;

    assign mode     = mode_e'(mode_i);
    assign mode_chg = (mode != mode_q);
    assign tick     = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign view_inc = {1'b0, view_idx} + 1'b1;

    // clear_i wins over a coincident byte: it is neither stored nor counted
    always_comb begin
        accept = 1'b0;
        if (rx_valid_i && !clear_i) begin
            case (mode)
                MODE_FIRST:  accept = !captured;
                MODE_LIVE:   accept = 1'b1;
                MODE_SCROLL: accept = 1'b1;
                default:     accept = 1'b0;
            endcase
        end
    end

    assign drop = rx_valid_i && !clear_i && !accept;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            mode_q   <= MODE_FIRST;
            tick_cnt <= '0;
        end else begin
            mode_q <= mode;
            if (mode_chg || tick) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            wr_ptr     <= '0;
            fill       <= '0;
            captured   <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            fill       <= '0;
            captured   <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                rx_count <= rx_count + 1'b1;
                if (fill != FULL)       fill     <= fill + 1'b1;
                if (mode == MODE_FIRST) captured <= 1'b1;
            end
            if (drop) drop_count <= drop_count + 1'b1;
        end
    end

    // view_idx is an offset from the newest entry, so a write during scrolling shifts the content
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            view_idx <= '0;
        end else if (clear_i || mode_chg) begin
            view_idx <= '0;
        end else if (mode == MODE_FIRST || mode == MODE_LIVE) begin
            view_idx <= '0;
        end else if (tick) begin
            if (view_inc >= fill) view_idx <= '0;
            else                  view_idx <= view_idx + 1'b1;
        end
    end

    always_ff @(posedge m_clock) begin
        if (accept) mem[wr_ptr] <= '{ferr: rx_ferr_i, perr: rx_perr_i, data: rx_data_i};
    end

    assign rd_ptr = wr_ptr - 1'b1 - view_idx;
    assign cur    = mem[rd_ptr];

    logic [4*NDIG+CNT_W-1:0] cnt_ext;
    logic [3:0]              nib [NDIG];
    logic                    dpl [NDIG];
    logic [7:0]              seg_raw [NDIG];
    logic [8*NDIG-1:0]       hex_d;
    logic [8*NDIG-1:0]       hex_q;

    assign cnt_ext = {{(4*NDIG){1'b0}}, rx_count};

    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            nib[k] = '0;
            dpl[k] = 1'b0;
        end
        nib[0] = cur.data[3:0];
        dpl[0] = cur.perr | cur.ferr;
        nib[1] = cur.data[7:4];
        nib[2] = 4'(view_idx);
        for (int k = 3; k < NDIG; k++) begin
            nib[k] = cnt_ext[4*(k-3) +: 4];
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        seg7_hex_enc u_enc (
            .nibble (nib[g]),
            .dp     (dpl[g]),
            .seg_n  (seg_raw[g])
        );
    end

    // Empty history shows dashes on the data digits; stale memory is never displayed
    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            hex_d[8*k +: 8] = seg_raw[k];
        end
        if (fill == '0) begin
            hex_d[7:0]  = ~SEG_DASH;
            hex_d[15:8] = ~SEG_DASH;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) hex_q <= '1;
        else          hex_q <= hex_d;
    end

    assign hex_o        = hex_q;
    assign rx_count_o   = rx_count;
    assign drop_count_o = drop_count;
    assign view_idx_o   = view_idx;

endmodule

// File: doc/uart_hex_monitor.md
Name: uart_hex_monitor

Overview:
- Parametrised successor to the single-byte UART display top.
- Consumes the byte stream from the UART receiver (`read`): valid pulse, data and error flags.
- Keeps a circular history of the last DEPTH bytes and drives NDIG active-low 7-segment digits.
- Four modes: first-capture, live, auto-scroll, hold. Auto-scroll uses a programmable tick.

Parameters:
- DEPTH, 8, history entries; power of two, 2..16.
- NDIG, 4, number of digits driven; NDIG >= 3.
- TICK_CYCLES, 120000000, m_clock cycles per scroll step.
- CNT_W, 16, width of the received/dropped byte counters.

Ports:
- m_clock  in  1  system clock.
- p_reset  in  1  asynchronous, active-low reset.
- rx_valid_i  in  1  one-cycle strobe, byte available (from RxD_Ready_o).
- rx_data_i  in  8  received byte.
- rx_perr_i  in  1  parity error flag for this byte.
- rx_ferr_i  in  1  framing error flag for this byte.
- mode_i  in  2  0=FIRST, 1=LIVE, 2=SCROLL, 3=HOLD.
- clear_i  in  1  synchronous clear of history and counters.
- hex_o  out  8*NDIG  active-low segments; digit k at [8k+7:8k]; bit7=dp, bits6:0=gfedcba.
- rx_count_o  out  CNT_W  bytes accepted into history (wraps).
- drop_count_o  out  CNT_W  bytes discarded (HOLD, or FIRST after capture; wraps).
- view_idx_o  out  log2(DEPTH)  displayed entry; 0 = newest.

Behaviour:
- Reset (p_reset low, async), all to 0 unless stated: wr_ptr, fill, view_idx, tick counter, counters, captured flag. hex_o = all 1s (all segments off).
- First clock after reset release: hex_o shows the empty display (below).
- Entry format: {ferr, perr, data[7:0]}, 10 bits.
- Write on rx_valid_i when accepted: store at wr_ptr; wr_ptr += 1 mod DEPTH; fill saturates at DEPTH; rx_count += 1.
- Full buffer: the oldest entry is overwritten; no stall.
- Acceptance by mode:
  - FIRST: accept only while captured flag = 0, then set it; later bytes go to drop_count.
  - LIVE and SCROLL: accept every byte.
  - HOLD: accept none; every byte goes to drop_count.
- Tick counter: counts 0..TICK_CYCLES-1 continuously; tick pulse = (count == TICK_CYCLES-1); count then returns to 0.
- view_idx by mode:
  - FIRST and LIVE: held at 0.
  - SCROLL and HOLD: on tick, view_idx += 1; wraps to 0 when view_idx+1 >= fill. With fill = 0 it stays 0.
- Mode change: when mode_i differs from its registered copy, view_idx <= 0 and the tick counter <= 0 on that edge.
- clear_i: wr_ptr, fill, view_idx, captured, rx_count, drop_count <= 0.
  - clear_i has priority over a simultaneous rx_valid_i; that byte is neither stored nor counted.
- Displayed entry = mem[(wr_ptr - 1 - view_idx) mod DEPTH].
- Display mapping, with E = the displayed entry:
  - digit0 = E.data[3:0]; its dp is lit if E.perr or E.ferr.
  - digit1 = E.data[7:4].
  - digit2 = view_idx.
  - digits 3..NDIG-1 = rx_count nibbles 0.. ; nibbles beyond CNT_W show 0.
- Empty display (fill = 0): digits 0 and 1 show dash (0x40); the other digits as normal.
- Segment encoding: hex table 0..F = 3F,06,5B,4F,66,6D,7D,27,7F,6F,77,7C,39,5E,79,71. Output is the bitwise inverse.
- Latency:
  - rx_valid_i at edge N: the entry is written at edge N.
  - hex_o is registered and reflects the new byte after edge N+1.
  - Counters update at edge N.
- Tick and write in the same cycle: both take effect. view_idx stays relative to the newest entry, so the display content shifts.

Decomposition:
- Package uart_mon_pkg:
  - SEG7_HEX[16] table, SEG_DASH=8'h40, SEG_DP=8'h80.
  - Mode constants MODE_FIRST/LIVE/SCROLL/HOLD.
  - Entry typedef {ferr, perr, data}.
- Sub-module seg7_hex_enc: 4-bit nibble + dp in, active-low 8-bit out, combinational. Instantiated NDIG times.
- History memory is inline (register array).

Test Plan:
- Reset, no input -> hex_o digit0 and digit1 = 8'hBF (dash), digit2 = 8'hC0, digit3 = 8'hC0; rx_count_o = 0.
- mode=FIRST, send 0x3A then 0x55 -> digit1 = ~8'h4F, digit0 = ~8'h77; rx_count_o = 1, drop_count_o = 1; the second byte is never shown.
- mode=LIVE, send 0x12 with perr=1 -> two edges later digit0 = ~(8'h5B|8'h80) = 8'h24, digit1 = ~8'h06 = 8'hF9.
- mode=SCROLL, TICK_CYCLES=4, DEPTH=4, send 0x01..0x06:
  - history holds 0x06,0x05,0x04,0x03.
  - view_idx steps 0,1,2,3,0 every 4 cycles.
  - digit0 shows 6,5,4,3,6.
- mode=HOLD, send 3 bytes -> rx_count_o unchanged, drop_count_o += 3, history unchanged.
- clear_i asserted together with rx_valid_i (data 0xFF) -> fill = 0, rx_count_o = 0, empty display next cycle.
- Async reset mid-SCROLL -> all state 0 immediately, hex_o = all 1s.
